wb_slave_mem: RTL and testbench

Synthesizable Wishbone B3 classic-cycle slave: a word-addressed RAM with programmable wait states and error termination. It is the responder counterpart to the wb_mast bus-functional master. It lets benches and the SoC template exercise ack/err/rty handling, wait states, byte lanes and aborted cycles against a known target. It sits on a Wishbone slave port, either directly under a wb_mast instance or behind the SoC interconnect.

---
 rtl/wb_slave_mem.sv | 146 ++++++++++++++
 tb/tb_wb_slave_mem.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_mem.sv
// wb_slave_mem: Wishbone B3 classic-cycle slave RAM (32-bit words, byte lanes).
// The wait state count is programmable. Misaligned and out-of-range accesses end
// with err. Defining WB_SLAVE_RETRY_EN makes every RETRY_PERIOD-th terminated
// transaction end with rty. Without the macro, wb_rty_o is tied to 0.
module wb_slave_mem #(
  parameter int MEM_WORDS    = 256,
  parameter int WAIT_STATES  = 1,
  parameter int RETRY_PERIOD = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, TERM} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] adr_q, dat_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic        start, bad, retry, commit;
  logic [31:0] rd_word;
  logic [31:0] mem [MEM_WORDS];

  assign start   = (state == IDLE) && wb_cyc_i && wb_stb_i;
  assign bad     = (|adr_q[1:0]) || (adr_q[31:2] >= 30'(MEM_WORDS));
  assign rd_word = mem[adr_q[AW+1:2]];
  // The RAM only changes on the edge that raises ack for a good, non-retried write.
  assign commit  = (state == TERM) && we_q && !bad && !retry;

`ifdef WB_SLAVE_RETRY_EN
  logic [7:0] txn_cnt;
  logic       rty_q;

  assign retry    = (txn_cnt == 8'(RETRY_PERIOD - 1));
  assign wb_rty_o = rty_q;

  // Count terminated transactions; the retried slot wraps the count to 0.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)            txn_cnt <= '0;
    else if (state == TERM)  txn_cnt <= retry ? 8'd0 : txn_cnt + 8'd1;
  end

  // Registered retry strobe, one cycle after the TERM state.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) rty_q <= 1'b0;
    else          rty_q <= (state == TERM) && retry;
  end
`else
  logic [7:0] unused_retry_period;

  assign unused_retry_period = 8'(RETRY_PERIOD);
  assign retry               = 1'b0;
  assign wb_rty_o            = 1'b0;
`endif

  // State and wait counter registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: an IDLE start goes to WAIT (or straight to TERM with no wait states).
  // WAIT aborts on a dropped cyc or stb. Abort has priority over the final count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (start) begin
        if (WAIT_STATES == 0) state_nxt = TERM;
        else begin
          state_nxt = WAIT;
          cnt_nxt   = 4'(WAIT_STATES);
        end
      end
      WAIT: begin
        if (!(wb_cyc_i && wb_stb_i)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == 4'd1) begin
          state_nxt = TERM;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt - 4'd1;
        end
      end
      TERM:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request at T0. Later changes on the bus are ignored.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q  <= 1'b0;
    end else if (start) begin
      adr_q <= wb_adr_i;
      dat_q <= wb_dat_i;
      sel_q <= wb_sel_i;
      we_q  <= wb_we_i;
    end
  end

  // Registered ack/err strobes and read data. The data is non-zero only for a read ack.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= (state == TERM) && !retry && !bad;
      wb_err_o <= (state == TERM) && !retry && bad;
      wb_dat_o <= ((state == TERM) && !retry && !bad && !we_q) ? rd_word : 32'h0;
    end
  end

  // Byte-lane RAM write. The RAM contents are deliberately not reset.
  always_ff @(posedge wb_clk_i) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) mem[adr_q[AW+1:2]][8*b +: 8] <= dat_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_slave_mem.sv
// Bench for wb_slave_mem: directed cases, then randomized Wishbone traffic.
// A word-level model predicts each termination. One compare process checks
// the strobes and read data on every cycle.
module tb_wb_slave_mem;
  localparam int MEM_WORDS = 256;
  localparam int WS        = 2;
  localparam int RP        = 4;
`ifdef WB_SLAVE_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] adr, dat_w, dat_r;
  logic [3:0]  sel;
  logic        cyc, stb, we, ack, err, rty;

  wb_slave_mem #(.MEM_WORDS(MEM_WORDS), .WAIT_STATES(WS), .RETRY_PERIOD(RP)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_r),
    .wb_sel_i(sel), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic        rty;
    logic        chk_dat;
    logic [31:0] dat;
  } exp_t;

  exp_t        exp_q [int];
  int          cyc_no = 0;
  int          checks = 0;
  int          passes = 0;
  logic [31:0] mdl [MEM_WORDS];
  int          n_term = 0;

  always @(posedge clk) cyc_no <= cyc_no + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h, want %h", name, got, want);
  endtask

  // Word-level model. It returns 0=ack, 1=err, 2=rty and applies any write.
  function automatic int model(input logic [31:0] a, input logic w, input logic [3:0] s,
                               input logic [31:0] d, output logic [31:0] rd);
    int kind;
    int word;
    word = int'(a >> 2);
    rd   = '0;
    if (RETRY && (n_term % RP) == RP - 1) kind = 2;
    else if (a[1:0] != 2'b00 || word >= MEM_WORDS) kind = 1;
    else begin
      kind = 0;
      if (w) begin
        for (int b = 0; b < 4; b++) if (s[b]) mdl[word][8*b +: 8] = d[8*b +: 8];
      end else rd = mdl[word];
    end
    n_term++;
    return kind;
  endfunction

  // Compare every cycle. Any cycle without a scheduled termination must be all zero.
  always @(negedge clk) begin
    exp_t e;
    e = '{ack: 1'b0, err: 1'b0, rty: 1'b0, chk_dat: 1'b1, dat: 32'h0};
    if (exp_q.exists(cyc_no)) begin
      if (!rst) e = exp_q[cyc_no];
      exp_q.delete(cyc_no);
    end
    checks++;
    if (ack === e.ack && err === e.err && rty === e.rty && (!e.chk_dat || dat_r === e.dat))
      passes++;
    else
      $display("FAIL bus cycle %0d: got ack=%b err=%b rty=%b dat=%h, want ack=%b err=%b rty=%b dat=%h",
               cyc_no, ack, err, rty, dat_r, e.ack, e.err, e.rty, e.dat);
  end

  task automatic scramble();
    adr   = $urandom;
    dat_w = $urandom;
    sel   = 4'($urandom);
    we    = 1'($urandom);
  endtask

  task automatic idle(input int n);
    cyc = 1'b0;
    stb = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Call just after a negedge with the slave idle.
  // mode: 0 = normal, 1 = abort by dropping cyc/stb at edge T0+abort_at, 2 = reset after T0.
  // A normal call returns at the negedge where the termination is visible.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d,
                      input int mode, input int abort_at, output int kind, output logic [31:0] rd);
    int          t0;
    int          mk;
    exp_t        e;
    logic [31:0] mrd;
    adr = a; we = w; sel = s; dat_w = d; cyc = 1'b1; stb = 1'b1;
    t0   = cyc_no + 1;
    kind = -1;
    rd   = '0;
    if (mode == 0) begin
      mk        = model(a, w, s, d, mrd);
      e.ack     = (mk == 0);
      e.err     = (mk == 1);
      e.rty     = (mk == 2);
      e.chk_dat = !(mk == 0 && w);
      e.dat     = mrd;
      exp_q[t0 + 1 + WS] = e;
    end
    @(posedge clk);
    if (mode == 1) begin
      for (int i = 1; i <= abort_at; i++) begin
        @(negedge clk);
        scramble();
        if (i == abort_at) begin
          if ($urandom_range(1) == 0) stb = 1'b0;
          else cyc = 1'b0;
        end
      end
      @(negedge clk);
    end else if (mode == 2) begin
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; rst = 1'b1;
      repeat (3) @(negedge clk);
      rst    = 1'b0;
      n_term = 0;
    end else begin
      @(negedge clk);
      scramble();
      repeat (1 + WS) @(negedge clk);
      kind = ack ? 0 : err ? 1 : rty ? 2 : -1;
      rd   = dat_r;
    end
  endtask

  // If the first attempt is retried, issue the same request once more.
  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d,
                       output int kind, output logic [31:0] rd);
    xfer(a, w, s, d, 0, 0, kind, rd);
    if (kind == 2) xfer(a, w, s, d, 0, 0, kind, rd);
  endtask

  initial begin
    int          k;
    logic [31:0] rd;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat_w = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset strobes", {29'b0, ack, err, rty}, 32'h0);
    check("reset dat", dat_r, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < MEM_WORDS; i++) issue(32'(i * 4), 1'b1, 4'hF, $urandom, k, rd);

    issue(32'h0, 1'b1, 4'hF, 32'h0BADF00D, k, rd);
    issue(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, k, rd);
    check("wr 0x10 ack", k, 32'd0);
    issue(32'h10, 1'b0, 4'hF, 32'h0, k, rd);
    check("rd 0x10 ack", k, 32'd0);
    check("rd 0x10 data", rd, 32'hDEADBEEF);

    issue(32'h20, 1'b1, 4'hF, 32'hAABBCCDD, k, rd);
    issue(32'h20, 1'b1, 4'b0101, 32'h11223344, k, rd);
    issue(32'h20, 1'b0, 4'h0, 32'h0, k, rd);
    check("lanes rd", rd, 32'hAA22CC44);
    check("model lanes", mdl[8], 32'hAA22CC44);
    issue(32'h20, 1'b1, 4'h0, 32'hFFFFFFFF, k, rd);
    check("sel0 wr ack", k, 32'd0);
    issue(32'h20, 1'b0, 4'hF, 32'h0, k, rd);
    check("sel0 rd", rd, 32'hAA22CC44);

    issue(32'h402, 1'b0, 4'hF, 32'h0, k, rd);
    check("misaligned err", k, 32'd1);
    check("misaligned dat", rd, 32'h0);
    issue(32'h400, 1'b1, 4'hF, 32'h12345678, k, rd);
    check("out of range err", k, 32'd1);
    issue(32'h3FC, 1'b1, 4'hF, 32'hCAFE0255, k, rd);
    check("last word ack", k, 32'd0);
    issue(32'h3FC, 1'b0, 4'hF, 32'h0, k, rd);
    check("last word rd", rd, 32'hCAFE0255);
    issue(32'h0, 1'b0, 4'hF, 32'h0, k, rd);
    check("word0 kept", rd, 32'h0BADF00D);

    issue(32'h30, 1'b1, 4'hF, 32'h30303030, k, rd);
    xfer(32'h30, 1'b1, 4'hF, 32'hFFFFFFFF, 1, WS, k, rd);
    idle(1);
    issue(32'h30, 1'b0, 4'hF, 32'h0, k, rd);
    check("after abort ack", k, 32'd0);
    check("after abort rd", rd, 32'h30303030);

    issue(32'h40, 1'b1, 4'hF, 32'h40404040, k, rd);
    xfer(32'h40, 1'b1, 4'hF, 32'hDEAD0000, 2, 0, k, rd);
    idle(1);
    for (int j = 1; j <= 4; j++) begin
      xfer(32'h0, 1'b0, 4'hF, 32'h0, 0, 0, k, rd);
      if (j < 4) check("retry seq early", k, 32'd0);
      else check("retry seq 4th", k, RETRY ? 32'd2 : 32'd0);
    end
    xfer(32'h0, 1'b0, 4'hF, 32'h0, 0, 0, k, rd);
    check("reissue ack", k, 32'd0);
    check("reissue rd", rd, 32'h0BADF00D);
    issue(32'h40, 1'b0, 4'hF, 32'h0, k, rd);
    check("reset dropped write", rd, 32'h40404040);

    issue(32'h50, 1'b1, 4'hF, 32'h50505050, k, rd);
    check("wr 0x50 ack", k, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    #2 rst = 1'b1;
    #1 check("async reset drops strobe", {29'b0, ack, err, rty}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    n_term = 0;
    issue(32'h50, 1'b0, 4'hF, 32'h0, k, rd);
    check("committed before reset", rd, 32'h50505050);

    for (int it = 0; it < 400; it++) begin
      logic [31:0] a;
      int          r;
      int          mode;
      r = $urandom_range(99);
      if (r < 80)      a = 32'($urandom_range(MEM_WORDS - 1)) << 2;
      else if (r < 90) a = (32'($urandom_range(MEM_WORDS - 1)) << 2) | 32'($urandom_range(3, 1));
      else if (r < 95) a = 32'($urandom_range(4 * MEM_WORDS - 1, MEM_WORDS)) << 2;
      else             a = $urandom & 32'hFFFF_FFFC | 32'h8000_0000;
      r    = $urandom_range(99);
      mode = (r < 8) ? 1 : (r < 10) ? 2 : 0;
      xfer(a, 1'($urandom), 4'($urandom), $urandom, mode, $urandom_range(WS, 1), k, rd);
      if (mode == 2) idle(1);
      else if ($urandom_range(1) == 1) idle($urandom_range(2, 1));
    end

    idle(4);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
